// File: rtl/alu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// alu_issue_scheduler
//   Reservation station and select logic for the two integer ALUs (UNIT_ID
//   0/1). Renamed ALU ops are accepted from dispatch. Operand values are
//   captured from the two CDB ports on wakeup. Up to two ready ops issue per
//   cycle, one to each ALU, through registered issue ports.
//
//   Optional build macro: ALU_SCHED_AGE_EN
//     defined   : oldest-first select. Each entry has an age counter that
//                 starts at 0 on dispatch, counts resident cycles and
//                 saturates at 15. Ties go to the lower index.
//     undefined : fixed-priority select, lowest index first, no age state.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush_i                    squash all entries and both issue registers
//   disp_valid_i/disp_ready_o  dispatch handshake (ready is combinational)
//   disp_op_i                  4-bit ALU opcode
//   disp_{a,b}_{rdy,tag,val}_i source operand state at dispatch
//   disp_rob_id_i, disp_pdest_i ROB id and physical destination
//   cdb{0,1}_{valid,tag,data}_i result broadcast ports (cdb0 has priority)
//   alu{0,1}_ready_i           ALU can accept an op this cycle
//   alu{0,1}_*_o               registered issue payload and valid
//   occupancy_o                number of valid entries
// ---------------------------------------------------------------------------
module alu_issue_scheduler #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 7,
    parameter int ROB_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  logic [3:0]               disp_op_i,
    input  logic                     disp_a_rdy_i,
    input  logic [TAG_W-1:0]         disp_a_tag_i,
    input  logic [31:0]              disp_a_val_i,
    input  logic                     disp_b_rdy_i,
    input  logic [TAG_W-1:0]         disp_b_tag_i,
    input  logic [31:0]              disp_b_val_i,
    input  logic [ROB_W-1:0]         disp_rob_id_i,
    input  logic [TAG_W-1:0]         disp_pdest_i,
    input  logic                     cdb0_valid_i,
    input  logic [TAG_W-1:0]         cdb0_tag_i,
    input  logic [31:0]              cdb0_data_i,
    input  logic                     cdb1_valid_i,
    input  logic [TAG_W-1:0]         cdb1_tag_i,
    input  logic [31:0]              cdb1_data_i,
    input  logic                     alu0_ready_i,
    input  logic                     alu1_ready_i,
    output logic                     alu0_valid_o,
    output logic [3:0]               alu0_op_o,
    output logic [31:0]              alu0_a_o,
    output logic [31:0]              alu0_b_o,
    output logic [ROB_W-1:0]         alu0_rob_id_o,
    output logic [TAG_W-1:0]         alu0_pdest_o,
    output logic                     alu1_valid_o,
    output logic [3:0]               alu1_op_o,
    output logic [31:0]              alu1_a_o,
    output logic [31:0]              alu1_b_o,
    output logic [ROB_W-1:0]         alu1_rob_id_o,
    output logic [TAG_W-1:0]         alu1_pdest_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Entry control state (reset) and payload state (no reset).
    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_a_rdy;
    logic [DEPTH-1:0] e_b_rdy;
    logic [3:0]       e_op    [DEPTH];
    logic [TAG_W-1:0] e_a_tag [DEPTH];
    logic [TAG_W-1:0] e_b_tag [DEPTH];
    logic [31:0]      e_a_val [DEPTH];
    logic [31:0]      e_b_val [DEPTH];
    logic [ROB_W-1:0] e_rob   [DEPTH];
    logic [TAG_W-1:0] e_pdest [DEPTH];
`ifdef ALU_SCHED_AGE_EN
    logic [3:0]       e_age   [DEPTH];
`endif

    // Snoop both CDB ports for a tag; returns {hit, data}. cdb0 wins a tie.
    function automatic logic [32:0] snoop(
        input logic [TAG_W-1:0] tag,
        input logic             v0,
        input logic [TAG_W-1:0] t0,
        input logic [31:0]      d0,
        input logic             v1,
        input logic [TAG_W-1:0] t1,
        input logic [31:0]      d1
    );
        if (v0 && (t0 == tag)) begin
            snoop = {1'b1, d0};
        end else if (v1 && (t1 == tag)) begin
            snoop = {1'b1, d1};
        end else begin
            snoop = 33'd0;
        end
    endfunction

    logic [32:0]      snp_a [DEPTH];
    logic [32:0]      snp_b [DEPTH];
    logic [DEPTH-1:0] wake_a;
    logic [DEPTH-1:0] wake_b;
    logic [32:0]      disp_snp_a;
    logic [32:0]      disp_snp_b;
    logic             disp_a_wake;
    logic             disp_b_wake;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp_a[i]  = snoop(e_a_tag[i], cdb0_valid_i, cdb0_tag_i, cdb0_data_i,
                              cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
            snp_b[i]  = snoop(e_b_tag[i], cdb0_valid_i, cdb0_tag_i, cdb0_data_i,
                              cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
            wake_a[i] = e_valid[i] && !e_a_rdy[i] && snp_a[i][32];
            wake_b[i] = e_valid[i] && !e_b_rdy[i] && snp_b[i][32];
        end
        disp_snp_a  = snoop(disp_a_tag_i, cdb0_valid_i, cdb0_tag_i, cdb0_data_i,
                            cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
        disp_snp_b  = snoop(disp_b_tag_i, cdb0_valid_i, cdb0_tag_i, cdb0_data_i,
                            cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
        disp_a_wake = !disp_a_rdy_i && disp_snp_a[32];
        disp_b_wake = !disp_b_rdy_i && disp_snp_b[32];
    end

    // Lowest-index free entry; only registered state counts, so a slot
    // freed by an issue this cycle is not reusable until the next one.
    logic             free_vld;
    logic [IDX_W-1:0] free_idx;
    logic             disp_fire;

    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!e_valid[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready_o = free_vld;
    assign disp_fire    = disp_valid_i && free_vld && !flush_i;

    // Select: best and second-best eligible entries.
    logic [DEPTH-1:0] elig;
    logic             first_vld;
    logic [IDX_W-1:0] first_idx;
    logic             second_vld;
    logic [IDX_W-1:0] second_idx;

    assign elig = e_valid & e_a_rdy & e_b_rdy;

    always_comb begin
        first_vld  = 1'b0;
        first_idx  = '0;
        second_vld = 1'b0;
        second_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i]) begin
`ifdef ALU_SCHED_AGE_EN
                if (!first_vld || (e_age[i] > e_age[first_idx])) begin
`else
                if (!first_vld) begin
`endif
                    first_vld = 1'b1;
                    first_idx = IDX_W'(i);
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && !(first_vld && (first_idx == IDX_W'(i)))) begin
`ifdef ALU_SCHED_AGE_EN
                if (!second_vld || (e_age[i] > e_age[second_idx])) begin
`else
                if (!second_vld) begin
`endif
                    second_vld = 1'b1;
                    second_idx = IDX_W'(i);
                end
            end
        end
    end

    // ALU1 takes the runner-up only when ALU0 claimed the best entry.
    logic             sel0_vld;
    logic [IDX_W-1:0] sel0_idx;
    logic             sel1_vld;
    logic [IDX_W-1:0] sel1_idx;

    always_comb begin
        sel0_vld = alu0_ready_i && first_vld;
        sel0_idx = first_idx;
        sel1_vld = 1'b0;
        sel1_idx = first_idx;
        if (alu1_ready_i) begin
            if (sel0_vld) begin
                sel1_vld = second_vld;
                sel1_idx = second_idx;
            end else begin
                sel1_vld = first_vld;
                sel1_idx = first_idx;
            end
        end
    end

    // Entry control update: flush dominates, then wakeup, issue-free and
    // dispatch. The dispatched slot is never valid this cycle, so its
    // writes cannot collide with wakeup or issue of the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= '0;
            e_a_rdy <= '0;
            e_b_rdy <= '0;
        end else if (flush_i) begin
            e_valid <= '0;
        end else begin
            e_a_rdy <= e_a_rdy | wake_a;
            e_b_rdy <= e_b_rdy | wake_b;
            if (sel0_vld) begin
                e_valid[sel0_idx] <= 1'b0;
            end
            if (sel1_vld) begin
                e_valid[sel1_idx] <= 1'b0;
            end
            if (disp_fire) begin
                e_valid[free_idx] <= 1'b1;
                e_a_rdy[free_idx] <= disp_a_rdy_i || disp_a_wake;
                e_b_rdy[free_idx] <= disp_b_rdy_i || disp_b_wake;
            end
        end
    end

`ifdef ALU_SCHED_AGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_age[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && (free_idx == IDX_W'(i))) begin
                    e_age[i] <= 4'd0;
                end else if (e_valid[i] && (e_age[i] != 4'd15)) begin
                    e_age[i] <= e_age[i] + 4'd1;
                end
            end
        end
    end
`endif

    // Entry payload capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wake_a[i]) begin
                e_a_val[i] <= snp_a[i][31:0];
            end
            if (wake_b[i]) begin
                e_b_val[i] <= snp_b[i][31:0];
            end
        end
        if (disp_fire) begin
            e_op[free_idx]    <= disp_op_i;
            e_a_tag[free_idx] <= disp_a_tag_i;
            e_b_tag[free_idx] <= disp_b_tag_i;
            e_a_val[free_idx] <= disp_a_wake ? disp_snp_a[31:0] : disp_a_val_i;
            e_b_val[free_idx] <= disp_b_wake ? disp_snp_b[31:0] : disp_b_val_i;
            e_rob[free_idx]   <= disp_rob_id_i;
            e_pdest[free_idx] <= disp_pdest_i;
        end
    end

    // Issue registers: stage boundary into the ALUs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu0_valid_o  <= 1'b0;
            alu0_op_o     <= '0;
            alu0_a_o      <= '0;
            alu0_b_o      <= '0;
            alu0_rob_id_o <= '0;
            alu0_pdest_o  <= '0;
            alu1_valid_o  <= 1'b0;
            alu1_op_o     <= '0;
            alu1_a_o      <= '0;
            alu1_b_o      <= '0;
            alu1_rob_id_o <= '0;
            alu1_pdest_o  <= '0;
        end else if (flush_i) begin
            alu0_valid_o <= 1'b0;
            alu1_valid_o <= 1'b0;
        end else begin
            alu0_valid_o <= sel0_vld;
            if (sel0_vld) begin
                alu0_op_o     <= e_op[sel0_idx];
                alu0_a_o      <= e_a_val[sel0_idx];
                alu0_b_o      <= e_b_val[sel0_idx];
                alu0_rob_id_o <= e_rob[sel0_idx];
                alu0_pdest_o  <= e_pdest[sel0_idx];
            end
            alu1_valid_o <= sel1_vld;
            if (sel1_vld) begin
                alu1_op_o     <= e_op[sel1_idx];
                alu1_a_o      <= e_a_val[sel1_idx];
                alu1_b_o      <= e_b_val[sel1_idx];
                alu1_rob_id_o <= e_rob[sel1_idx];
                alu1_pdest_o  <= e_pdest[sel1_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_o <= '0;
        end else if (flush_i) begin
            occupancy_o <= '0;
        end else begin
            occupancy_o <= occupancy_o + CNT_W'(disp_fire)
                           - CNT_W'(sel0_vld) - CNT_W'(sel1_vld);
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_scheduler
//   Directed bench for alu_issue_scheduler (DEPTH=8, TAG_W=7, ROB_W=6).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
//   The oldest-first scenario is compiled only when ALU_SCHED_AGE_EN is set.
// ---------------------------------------------------------------------------
module tb_alu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_op;
    logic        disp_a_rdy;
    logic [6:0]  disp_a_tag;
    logic [31:0] disp_a_val;
    logic        disp_b_rdy;
    logic [6:0]  disp_b_tag;
    logic [31:0] disp_b_val;
    logic [5:0]  disp_rob_id;
    logic [6:0]  disp_pdest;
    logic        cdb0_valid;
    logic [6:0]  cdb0_tag;
    logic [31:0] cdb0_data;
    logic        cdb1_valid;
    logic [6:0]  cdb1_tag;
    logic [31:0] cdb1_data;
    logic        alu0_ready;
    logic        alu1_ready;
    logic        alu0_valid;
    logic [3:0]  alu0_op;
    logic [31:0] alu0_a;
    logic [31:0] alu0_b;
    logic [5:0]  alu0_rob_id;
    logic [6:0]  alu0_pdest;
    logic        alu1_valid;
    logic [3:0]  alu1_op;
    logic [31:0] alu1_a;
    logic [31:0] alu1_b;
    logic [5:0]  alu1_rob_id;
    logic [6:0]  alu1_pdest;
    logic [3:0]  occupancy;

    int checks = 0;
    int fails  = 0;

    alu_issue_scheduler #(.DEPTH(8), .TAG_W(7), .ROB_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .disp_valid_i  (disp_valid),
        .disp_ready_o  (disp_ready),
        .disp_op_i     (disp_op),
        .disp_a_rdy_i  (disp_a_rdy),
        .disp_a_tag_i  (disp_a_tag),
        .disp_a_val_i  (disp_a_val),
        .disp_b_rdy_i  (disp_b_rdy),
        .disp_b_tag_i  (disp_b_tag),
        .disp_b_val_i  (disp_b_val),
        .disp_rob_id_i (disp_rob_id),
        .disp_pdest_i  (disp_pdest),
        .cdb0_valid_i  (cdb0_valid),
        .cdb0_tag_i    (cdb0_tag),
        .cdb0_data_i   (cdb0_data),
        .cdb1_valid_i  (cdb1_valid),
        .cdb1_tag_i    (cdb1_tag),
        .cdb1_data_i   (cdb1_data),
        .alu0_ready_i  (alu0_ready),
        .alu1_ready_i  (alu1_ready),
        .alu0_valid_o  (alu0_valid),
        .alu0_op_o     (alu0_op),
        .alu0_a_o      (alu0_a),
        .alu0_b_o      (alu0_b),
        .alu0_rob_id_o (alu0_rob_id),
        .alu0_pdest_o  (alu0_pdest),
        .alu1_valid_o  (alu1_valid),
        .alu1_op_o     (alu1_op),
        .alu1_a_o      (alu1_a),
        .alu1_b_o      (alu1_b),
        .alu1_rob_id_o (alu1_rob_id),
        .alu1_pdest_o  (alu1_pdest),
        .occupancy_o   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op,
                        input logic a_rdy, input logic [6:0] a_tag, input logic [31:0] a_val,
                        input logic b_rdy, input logic [6:0] b_tag, input logic [31:0] b_val,
                        input logic [5:0] rob, input logic [6:0] pdest);
        disp_valid  = 1'b1;
        disp_op     = op;
        disp_a_rdy  = a_rdy;
        disp_a_tag  = a_tag;
        disp_a_val  = a_val;
        disp_b_rdy  = b_rdy;
        disp_b_tag  = b_tag;
        disp_b_val  = b_val;
        disp_rob_id = rob;
        disp_pdest  = pdest;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0;
        disp_a_rdy = 1'b0; disp_a_tag = '0; disp_a_val = '0;
        disp_b_rdy = 1'b0; disp_b_tag = '0; disp_b_val = '0;
        disp_rob_id = '0; disp_pdest = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
        alu0_ready = 1'b1; alu1_ready = 1'b1;

        // Reset state
        step();
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_alu0_valid", 32'(alu0_valid), 32'd0);
        chk("rst_alu1_valid", 32'(alu1_valid), 32'd0);
        chk("rst_alu0_a", alu0_a, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: ready ADD issues two edges after dispatch
        disp(4'h0, 1'b1, 7'h00, 32'd5, 1'b1, 7'h00, 32'd7, 6'd1, 7'd10);
        step();
        disp_valid = 1'b0;
        chk("t1_occ_after_disp", 32'(occupancy), 32'd1);
        chk("t1_not_yet_valid", 32'(alu0_valid), 32'd0);
        step();
        chk("t1_alu0_valid", 32'(alu0_valid), 32'd1);
        chk("t1_alu0_a", alu0_a, 32'd5);
        chk("t1_alu0_b", alu0_b, 32'd7);
        chk("t1_alu0_rob", 32'(alu0_rob_id), 32'd1);
        chk("t1_alu0_pdest", 32'(alu0_pdest), 32'd10);
        chk("t1_alu1_valid", 32'(alu1_valid), 32'd0);
        chk("t1_occ_zero", 32'(occupancy), 32'd0);
        step();
        chk("t1_valid_drops", 32'(alu0_valid), 32'd0);

        // 2: wakeup on cdb1
        disp(4'h1, 1'b0, 7'h12, 32'd0, 1'b1, 7'h00, 32'd3, 6'd2, 7'd11);
        step();
        disp_valid = 1'b0;
        cdb1_valid = 1'b1; cdb1_tag = 7'h12; cdb1_data = 32'hDEAD;
        step();
        cdb1_valid = 1'b0;
        chk("t2_not_eligible_at_wake", 32'(alu0_valid), 32'd0);
        step();
        chk("t2_alu0_valid", 32'(alu0_valid), 32'd1);
        chk("t2_alu0_a", alu0_a, 32'hDEAD);
        chk("t2_alu0_b", alu0_b, 32'd3);
        chk("t2_alu0_op", 32'(alu0_op), 32'd1);

        // 2b: both CDB ports match, cdb0 wins
        disp(4'h2, 1'b0, 7'h15, 32'd0, 1'b1, 7'h00, 32'd1, 6'd3, 7'd12);
        step();
        disp_valid = 1'b0;
        cdb0_valid = 1'b1; cdb0_tag = 7'h15; cdb0_data = 32'h111;
        cdb1_valid = 1'b1; cdb1_tag = 7'h15; cdb1_data = 32'h222;
        step();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        step();
        chk("t2b_cdb0_priority", alu0_a, 32'h111);

        // 2c: wakeup of both operands in the dispatch cycle
        disp(4'h3, 1'b0, 7'h16, 32'd0, 1'b0, 7'h17, 32'd0, 6'd4, 7'd13);
        cdb0_valid = 1'b1; cdb0_tag = 7'h16; cdb0_data = 32'h77;
        cdb1_valid = 1'b1; cdb1_tag = 7'h17; cdb1_data = 32'h88;
        step();
        disp_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        chk("t2c_occ", 32'(occupancy), 32'd1);
        step();
        chk("t2c_alu0_valid", 32'(alu0_valid), 32'd1);
        chk("t2c_alu0_a", alu0_a, 32'h77);
        chk("t2c_alu0_b", alu0_b, 32'h88);

        // 3: three ready ops, dual issue then single
        alu0_ready = 1'b0; alu1_ready = 1'b0;
        disp(4'h0, 1'b1, 7'h00, 32'd1, 1'b1, 7'h00, 32'd0, 6'd5, 7'd20);
        step();
        disp(4'h0, 1'b1, 7'h00, 32'd2, 1'b1, 7'h00, 32'd0, 6'd6, 7'd21);
        step();
        disp(4'h0, 1'b1, 7'h00, 32'd3, 1'b1, 7'h00, 32'd0, 6'd7, 7'd22);
        step();
        disp_valid = 1'b0;
        chk("t3_occ3", 32'(occupancy), 32'd3);
        chk("t3_held_alu0", 32'(alu0_valid), 32'd0);
        alu0_ready = 1'b1; alu1_ready = 1'b1;
        step();
        chk("t3_alu0_valid", 32'(alu0_valid), 32'd1);
        chk("t3_alu0_rob", 32'(alu0_rob_id), 32'd5);
        chk("t3_alu1_valid", 32'(alu1_valid), 32'd1);
        chk("t3_alu1_rob", 32'(alu1_rob_id), 32'd6);
        chk("t3_alu1_a", alu1_a, 32'd2);
        chk("t3_occ1", 32'(occupancy), 32'd1);
        step();
        chk("t3_third_alu0_rob", 32'(alu0_rob_id), 32'd7);
        chk("t3_third_alu0_valid", 32'(alu0_valid), 32'd1);
        chk("t3_third_alu1_idle", 32'(alu1_valid), 32'd0);
        chk("t3_occ0", 32'(occupancy), 32'd0);

        // 3b: one ALU not ready
        alu0_ready = 1'b0; alu1_ready = 1'b0;
        disp(4'h4, 1'b1, 7'h00, 32'd8, 1'b1, 7'h00, 32'd0, 6'd8, 7'd23);
        step();
        disp(4'h5, 1'b1, 7'h00, 32'd9, 1'b1, 7'h00, 32'd0, 6'd9, 7'd24);
        step();
        disp_valid = 1'b0;
        alu0_ready = 1'b1;
        step();
        chk("t3b_alu0_rob", 32'(alu0_rob_id), 32'd8);
        chk("t3b_alu1_blocked", 32'(alu1_valid), 32'd0);
        chk("t3b_occ", 32'(occupancy), 32'd1);
        alu0_ready = 1'b0; alu1_ready = 1'b1;
        step();
        chk("t3b_alu1_takes_first", 32'(alu1_valid), 32'd1);
        chk("t3b_alu1_rob", 32'(alu1_rob_id), 32'd9);
        chk("t3b_alu0_idle", 32'(alu0_valid), 32'd0);
        alu0_ready = 1'b1;

        // 4: fill, drop, wake one
        for (int i = 0; i < 8; i++) begin
            disp(4'h0, 1'b0, 7'(32 + i), 32'd0, 1'b1, 7'h00, 32'd0, 6'(16 + i), 7'd30);
            step();
        end
        chk("t4_full_ready", 32'(disp_ready), 32'd0);
        chk("t4_full_occ", 32'(occupancy), 32'd8);
        disp(4'h0, 1'b1, 7'h00, 32'd0, 1'b1, 7'h00, 32'd0, 6'd30, 7'd31);
        step();
        disp_valid = 1'b0;
        chk("t4_drop_occ", 32'(occupancy), 32'd8);
        cdb0_valid = 1'b1; cdb0_tag = 7'h23; cdb0_data = 32'h33;
        step();
        cdb0_valid = 1'b0;
        chk("t4_no_issue_of_dropped", 32'(alu0_valid), 32'd0);
        chk("t4_still_full", 32'(disp_ready), 32'd0);
        step();
        chk("t4_issue_valid", 32'(alu0_valid), 32'd1);
        chk("t4_issue_rob", 32'(alu0_rob_id), 32'd19);
        chk("t4_issue_a", alu0_a, 32'h33);
        chk("t4_occ7", 32'(occupancy), 32'd7);
        chk("t4_ready_back", 32'(disp_ready), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_occ", 32'(occupancy), 32'd0);

        // 5: flush with 5 entries and both issue regs valid
        alu0_ready = 1'b0; alu1_ready = 1'b0;
        disp(4'h0, 1'b1, 7'h00, 32'h40, 1'b1, 7'h00, 32'd0, 6'd40, 7'd40);
        step();
        disp(4'h0, 1'b1, 7'h00, 32'h41, 1'b1, 7'h00, 32'd0, 6'd41, 7'd41);
        step();
        for (int i = 0; i < 5; i++) begin
            disp(4'h0, 1'b0, 7'(64 + i), 32'd0, 1'b1, 7'h00, 32'd0, 6'(42 + i), 7'd42);
            step();
        end
        disp_valid = 1'b0;
        chk("t5_occ7", 32'(occupancy), 32'd7);
        alu0_ready = 1'b1; alu1_ready = 1'b1;
        step();
        chk("t5_alu0_valid", 32'(alu0_valid), 32'd1);
        chk("t5_alu1_valid", 32'(alu1_valid), 32'd1);
        chk("t5_occ5", 32'(occupancy), 32'd5);
        flush = 1'b1;
        disp(4'h0, 1'b1, 7'h00, 32'd0, 1'b1, 7'h00, 32'd0, 6'd50, 7'd50);
        cdb0_valid = 1'b1; cdb0_tag = 7'h40; cdb0_data = 32'h5;
        step();
        flush = 1'b0; disp_valid = 1'b0; cdb0_valid = 1'b0;
        chk("t5_flush_occ", 32'(occupancy), 32'd0);
        chk("t5_flush_alu0", 32'(alu0_valid), 32'd0);
        chk("t5_flush_alu1", 32'(alu1_valid), 32'd0);
        chk("t5_flush_ready", 32'(disp_ready), 32'd1);
        step();
        chk("t5_disp_not_written", 32'(alu0_valid), 32'd0);
        chk("t5_occ_stays0", 32'(occupancy), 32'd0);

`ifdef ALU_SCHED_AGE_EN
        // 6: older entry at index 3 beats younger at index 0
        for (int i = 0; i < 4; i++) begin
            disp(4'h0, 1'b0, 7'(96 + i), 32'd0, 1'b1, 7'h00, 32'd0, 6'(i), 7'd60);
            step();
        end
        disp_valid = 1'b0;
        cdb0_valid = 1'b1; cdb0_tag = 7'h60; cdb0_data = 32'd1;
        cdb1_valid = 1'b1; cdb1_tag = 7'h61; cdb1_data = 32'd1;
        step();
        cdb0_tag = 7'h62; cdb1_valid = 1'b0;
        step();
        cdb0_valid = 1'b0;
        step();
        step();
        chk("t6_one_left", 32'(occupancy), 32'd1);
        disp(4'h0, 1'b0, 7'h63, 32'd0, 1'b1, 7'h00, 32'd0, 6'd9, 7'd61);
        step();
        disp_valid = 1'b0;
        step();
        cdb0_valid = 1'b1; cdb0_tag = 7'h63; cdb0_data = 32'h99;
        step();
        cdb0_valid = 1'b0;
        step();
        chk("t6_alu0_oldest", 32'(alu0_rob_id), 32'd3);
        chk("t6_alu1_younger", 32'(alu1_rob_id), 32'd9);
`endif

        // Asynchronous reset mid-operation
        disp(4'h0, 1'b1, 7'h00, 32'd1, 1'b1, 7'h00, 32'd2, 6'd11, 7'd70);
        step();
        disp_valid = 1'b0;
        step();
        chk("ar_pre_valid", 32'(alu0_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_drop", 32'(alu0_valid), 32'd0);
        chk("ar_a_clear", alu0_a, 32'd0);
        chk("ar_ready", 32'(disp_ready), 32'd1);
        chk("ar_occ", 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
